// File: rtl/truth_table_monitor_pkg.sv
// Shared types and constants for the truth-table monitor.
package tt_mon_pkg;

  typedef enum logic {
    SETTLE = 1'b0,
    HELD   = 1'b1
  } state_t;

  typedef logic [2:0] tt_idx_t;
  typedef logic [7:0] tt_vec_t;

  localparam tt_vec_t     TT_FULL = 8'hFF;
  localparam int unsigned VALUE_W = 4;

endpackage

// File: rtl/truth_table_monitor_settle_detect.sv
// Emits one capture strobe per stable period of a multi-bit value once it has
// held for SETTLE_CYCLES edges after first being sampled.
module settle_detect
  import tt_mon_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [VALUE_W-1:0] value,
  output logic               capture_c
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_n;
  logic [VALUE_W-1:0] prev;
  logic               changed_c;

  assign changed_c = (value != prev);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state <= SETTLE;
      cnt   <= '0;
      prev  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      prev  <= value;
    end
  end

  // A change on the would-be capture edge wins and restarts settling.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    capture_c = 1'b0;
    if (changed_c) begin
      state_n = SETTLE;
      cnt_n   = '0;
    end else begin
      if (cnt != CNT_W'(SETTLE_CYCLES)) begin
        cnt_n = cnt + CNT_W'(1);
      end
      if ((state == SETTLE) && (cnt == CNT_W'(SETTLE_CYCLES - 1))) begin
        capture_c = 1'b1;
        state_n   = HELD;
      end
    end
  end

endmodule

// File: rtl/truth_table_monitor.sv
// Captures a settled DUT response per {A,B,C} combination into a truth table,
// tracks coverage and conflicts, and compares the full table against EXP_TT.
module truth_table_monitor
  import tt_mon_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXP_TT        = 8'hE8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       F,
  output logic [7:0] tt,
  output logic [7:0] covered,
  output logic       sample_valid,
  output logic [2:0] sample_idx,
  output logic       conflict,
  output logic       done,
  output logic       pass
);

  logic [VALUE_W-1:0] value;
  tt_idx_t            idx;
  logic               capture_c;
  tt_vec_t            tt_n;
  tt_vec_t            covered_n;
  logic               conflict_n;
  logic               done_n;
  logic               pass_n;

  assign value = {A, B, C, F};
  assign idx   = {A, B, C};

  settle_detect #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .value    (value),
    .capture_c(capture_c)
  );

  // First capture of an index is authoritative; later disagreement only flags.
  always_comb begin
    tt_n       = tt;
    covered_n  = covered;
    conflict_n = conflict;
    if (capture_c) begin
      if (!covered[idx]) begin
        tt_n[idx]      = F;
        covered_n[idx] = 1'b1;
      end else if (tt[idx] != F) begin
        conflict_n = 1'b1;
      end
    end
    done_n = (covered_n == TT_FULL);
    pass_n = done_n && (tt_n == EXP_TT) && !conflict_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      tt           <= '0;
      covered      <= '0;
      sample_valid <= 1'b0;
      sample_idx   <= '0;
      conflict     <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
    end else begin
      tt           <= tt_n;
      covered      <= covered_n;
      sample_valid <= capture_c;
      if (capture_c) begin
        sample_idx <= idx;
      end
      conflict     <= conflict_n;
      done         <= done_n;
      pass         <= pass_n;
    end
  end

endmodule

// File: doc/truth_table_monitor.md
Name: truth_table_monitor

Overview:
- Response-side partner to the exhaustive 3-input stimulus sequences used across the lab exercises.
- Observes the stimulus {A,B,C} and the DUT output F in hardware. Waits for each input combination to settle, then captures F into an 8-entry truth table.
- Tracks which combinations have been covered and flags conflicting captures.
- Compares the completed table against an expected truth table and reports pass/fail; sits beside the DUT on the board or in simulation.

Parameters:
- SETTLE_CYCLES, 4, cycles {A,B,C,F} must hold unchanged before capture; legal range ≥1.
- EXP_TT, 8'hE8, expected truth table; bit index = {A,B,C} (A is MSB).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- clr  in  1  synchronous clear of table/coverage/flags, same effect as reset
- A  in  1  stimulus bit 2 (MSB of index)
- B  in  1  stimulus bit 1
- C  in  1  stimulus bit 0
- F  in  1  DUT response
- tt  out  8  captured truth table
- covered  out  8  bit i = 1 once index i has been captured
- sample_valid  out  1  one-cycle pulse on each capture
- sample_idx  out  3  index of last capture
- conflict  out  1  sticky: an index was re-captured with a different F
- done  out  1  covered == 8'hFF
- pass  out  1  done && (tt == EXP_TT) && !conflict

Behaviour:
- All logic is clocked on clk. Reset and clr take effect at the edge; reset has priority over clr. clr has priority over capture in the same cycle.
- Reset and clr values:
  - tt, covered, sample_idx = 0
  - sample_valid, conflict, done, pass = 0
  - prev = 0, cnt = 0, state = SETTLE
- prev holds {A,B,C,F} sampled at the previous edge. cnt width is $clog2(SETTLE_CYCLES+1) and saturates at SETTLE_CYCLES.
- Change detection: at each edge, if current {A,B,C,F} != prev, then cnt <= 0 and state <= SETTLE. prev is updated every cycle.
- FSM states:
  - SETTLE: on an edge where the value is unchanged, cnt increments. When cnt == SETTLE_CYCLES-1 at an unchanged edge, capture and go to HELD.
  - HELD: no further capture until the value changes, which returns to SETTLE. This guarantees exactly one capture per stable period.
- Capture timing: value first sampled at edge k. Capture occurs at edge k+SETTLE_CYCLES, and outputs reflect it after that edge.
- Capture action:
  - sample_valid = 1 for one cycle; sample_idx = idx.
  - If covered[idx] == 0: tt[idx] <= F and covered[idx] <= 1.
  - Else if tt[idx] != F: conflict <= 1. tt keeps the first value.
  - Else: no table change.
- Glitch filtering: any value held fewer than SETTLE_CYCLES+1 consecutive samples is never captured.
- done, pass: registered, derived from next-state values, so they update on the same edge as the capture that completes coverage.
- After done, monitoring continues; a later conflict clears pass. Re-covering an index does not re-pulse done.
- First value after reset is treated as a change from prev=0 only if it differs. A stable 0000 input is captured at edge SETTLE_CYCLES after reset release.
- A change coinciding with the capture edge cancels the capture (change wins).

Decomposition:
- Package tt_mon_pkg:
  - state enum {SETTLE, HELD}
  - typedef tt_idx_t logic[2:0]
  - typedef tt_vec_t logic[7:0]
  - constant TT_FULL = 8'hFF
- One sub-module, settle_detect (parameter SETTLE_CYCLES): inputs clk, rst_n, clr, 4-bit value; output one-cycle capture strobe. Contains prev, cnt and the FSM. The top level holds the table, coverage, conflict and pass logic.

Test Plan:
- Exhaustive sweep 000..111, each held 100 cycles, F = majority(A,B,C):
  - tt = 8'hE8, covered = 8'hFF, done = 1, pass = 1, conflict = 0.
  - Exactly 8 sample_valid pulses.
- Timing: from reset with inputs static 0, then {A,B,C,F} = 1011 applied at edge k:
  - sample_valid high exactly after edge k+4, sample_idx = 5, tt[5] = 1.
  - No second pulse while the value is held.
- Glitch: 3'b010 held 3 cycles between two long-held values with SETTLE_CYCLES = 4 → covered[2] stays 0, no pulse for idx 2.
- Conflict: capture idx 3 with F = 1, move away, return to idx 3 with F = 0 → conflict = 1, tt[3] = 1, pass = 0 after the sweep completes.
- Wrong DUT: sweep with F = A^B^C (tt = 8'h96) → done = 1, pass = 0, conflict = 0.
- Clear and reset: clr asserted after 5 captures → all outputs 0 next cycle; sweep restart reaches pass = 1. Same check with rst_n low for 1 cycle mid-sweep.
